shr_unit: RTL and testbench
===========================

SHR_UNIT -- requirements
Module: shr_unit

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-004 The module SHALL have port in_ready, output, 1 bit: unit can accept an operand request.
REQ-005 The module SHALL have port in1, input, 8 bits: value to be shifted.
REQ-006 The module SHALL have port in2, input, 8 bits: unsigned shift amount.
REQ-007 The module SHALL have port alu_control, input, 1 bit: 1 = shift right, 0 = pass in1 unchanged.
REQ-008 The module SHALL have port arith, input, 1 bit: 1 = arithmetic (sign-fill) shift; meaning per REQ-024/025.
REQ-009 The module SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-011 The module SHALL have port result, output, 8 bits: shifted value.
REQ-012 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 On accept (in_valid & in_ready at cycle T): latch in1 into an 8-bit working register, latch mode and arith, and load a 4-bit counter n = alu_control ? min(in2,8) : 0.
REQ-015 From IDLE, on accept: go to SHIFT if n>0, else DONE.
REQ-016 In SHIFT: each cycle shift the working register right by one, fill bit = arith ? reg[7] : 0, and decrement n; on the cycle n reaches 0, go to DONE.
REQ-017 Latency: out_valid SHALL rise at cycle T+1+n, so the maximum is T+9.
REQ-018 Shift amounts 8..255 SHALL saturate to 8 iterations: result 0x00 for a logical shift, and 0x00/0xFF per the sign for an arithmetic shift.
REQ-019 In DONE: result and out_valid SHALL hold stable until out_ready=1; on out_valid & out_ready, return to IDLE the next cycle.
REQ-020 Inputs SHALL be ignored outside IDLE; in_valid during SHIFT/DONE is not accepted and not queued.
REQ-021 result SHALL always drive the working register; its value is only meaningful while out_valid=1.

Reset
REQ-022 While rst=1, asynchronously: state=IDLE, working register=0x00, n=0, latched mode/arith=0, so result=0x00, out_valid=0, busy=0 and in_ready=1 after release.
REQ-023 Reset asserted mid-SHIFT or in DONE SHALL abandon the operation; no out_valid follows for that request.

Configuration
REQ-024 With SHR_ARITH_EN defined, arith SHALL select sign fill per REQ-016.
REQ-025 Without SHR_ARITH_EN, the arith port SHALL remain present but be ignored (fill always 0), and its latch SHALL be omitted.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), the data width DW=8, and the saturation limit SHAMT_MAX=8.
REQ-027 The block SHALL be a single module with no sub-modules; the FSM, counter and shift register together are 120-200 lines.

Verification
REQ-028 in1=0xB4, in2=2, alu_control=1, arith=0, accepted at T -> out_valid at T+3, result=0x2D.
REQ-029 (SHR_ARITH_EN) in1=0xB4, in2=2, arith=1 -> result=0xED at T+3; with the macro undefined, the same stimulus -> 0x2D.
REQ-030 in1=0x80, in2=200, arith=1 -> result=0xFF at T+9; with arith=0 -> 0x00 at T+9.
REQ-031 alu_control=0, in1=0x5A, in2=7 -> result=0x5A at T+1; out_ready held low for 5 cycles -> result/out_valid stable, in_ready=0, and a second in_valid is ignored.
REQ-032 rst pulsed at T+2 of an in2=6 request -> outputs reset immediately, no out_valid follows, and a fresh request accepted afterwards completes correctly.

Source files
------------

// File: rtl/shr_unit_pkg.sv
// rtl/shr_unit_pkg.sv - shared state encoding, widths and saturation helper for shr_unit
package shr_unit_pkg;

  localparam int DW        = 8;
  localparam int SHAMT_MAX = 8;
  localparam int CW        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Clamp a shift amount to SHAMT_MAX; beyond that every bit is already filled.
  function automatic logic [CW-1:0] sat_shamt(input logic [DW-1:0] amt);
    if (amt >= DW'(SHAMT_MAX)) begin
      return CW'(SHAMT_MAX);
    end
    return amt[CW-1:0];
  endfunction

endpackage

// File: rtl/shr_unit.sv
// rtl/shr_unit.sv - iterative one-bit-per-cycle right shifter with valid/ready handshake (SHR_ARITH_EN enables sign fill)
module shr_unit
  import shr_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic          alu_control,
  input  logic          arith,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [DW-1:0] work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          fill;
  logic [CW-1:0] load_cnt;

`ifdef SHR_ARITH_EN
  logic          arith_q, arith_d;

  // Sign fill replicates the current MSB only when the request asked for it.
  assign fill = arith_q & work_q[DW-1];
`else
  logic          unused_arith;

  // The arith port is kept for interface compatibility but has no effect.
  assign unused_arith = arith;
  assign fill         = 1'b0;
`endif

  assign load_cnt  = alu_control ? sat_shamt(in2) : '0;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = work_q;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
`ifdef SHR_ARITH_EN
      arith_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
`ifdef SHR_ARITH_EN
      arith_q <= arith_d;
`endif
    end
  end

  // Next-state, counter and working-register update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
`ifdef SHR_ARITH_EN
    arith_d = arith_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in1;
          mode_d  = alu_control;
          cnt_d   = load_cnt;
`ifdef SHR_ARITH_EN
          arith_d = arith;
`endif
          state_d = (load_cnt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (mode_q) begin
          work_d = {fill, work_q[DW-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        // Counter is at least 1 here; leaving on the final decrement.
        if (cnt_q <= CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shr_unit.sv
// tb/tb_shr_unit.sv - directed self-checking bench for shr_unit
module tb_shr_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       alu_control;
  logic       arith;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  shr_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .alu_control (alu_control),
    .arith       (arith),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c, input logic ar,
                       output int lat, output logic [7:0] res);
    @(negedge clk);
    in1 = a; in2 = b; alu_control = c; arith = ar; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (result !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_state: result=%h out_valid=%b busy=%b expected 00/0/0", result, out_valid, busy);
    end else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_release: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end else pass_cnt++;
  endtask

  task automatic test_logical();
    int lat;
    logic [7:0] res;
    issue(8'hB4, 8'd2, 1'b1, 1'b0, lat, res);
    total_cnt++;
    if (lat !== 3 || res !== 8'h2D) begin
      $display("FAIL logical_b4_2: lat=%0d result=%h expected 3/2d", lat, res);
    end else pass_cnt++;
    release_result();
    issue(8'h96, 8'd3, 1'b1, 1'b0, lat, res);
    total_cnt++;
    if (lat !== 4 || res !== 8'h12) begin
      $display("FAIL logical_96_3: lat=%0d result=%h expected 4/12", lat, res);
    end else pass_cnt++;
    release_result();
    issue(8'hC3, 8'd0, 1'b1, 1'b1, lat, res);
    total_cnt++;
    if (lat !== 1 || res !== 8'hC3) begin
      $display("FAIL shift_zero: lat=%0d result=%h expected 1/c3", lat, res);
    end else pass_cnt++;
    release_result();
  endtask

  task automatic test_arith();
    int lat;
    logic [7:0] res;
    logic [7:0] exp;
`ifdef SHR_ARITH_EN
    exp = 8'hED;
`else
    exp = 8'h2D;
`endif
    issue(8'hB4, 8'd2, 1'b1, 1'b1, lat, res);
    total_cnt++;
    if (lat !== 3 || res !== exp) begin
      $display("FAIL arith_b4_2: lat=%0d result=%h expected 3/%h", lat, res, exp);
    end else pass_cnt++;
    release_result();
  endtask

  task automatic test_saturate();
    int lat;
    logic [7:0] res;
    logic [7:0] exp;
`ifdef SHR_ARITH_EN
    exp = 8'hFF;
`else
    exp = 8'h00;
`endif
    issue(8'h80, 8'd200, 1'b1, 1'b1, lat, res);
    total_cnt++;
    if (lat !== 9 || res !== exp) begin
      $display("FAIL sat_arith_200: lat=%0d result=%h expected 9/%h", lat, res, exp);
    end else pass_cnt++;
    release_result();
    issue(8'h80, 8'd200, 1'b1, 1'b0, lat, res);
    total_cnt++;
    if (lat !== 9 || res !== 8'h00) begin
      $display("FAIL sat_logical_200: lat=%0d result=%h expected 9/00", lat, res);
    end else pass_cnt++;
    release_result();
    issue(8'hFF, 8'd8, 1'b1, 1'b0, lat, res);
    total_cnt++;
    if (lat !== 9 || res !== 8'h00) begin
      $display("FAIL shamt_8: lat=%0d result=%h expected 9/00", lat, res);
    end else pass_cnt++;
    release_result();
    issue(8'hFF, 8'd7, 1'b1, 1'b0, lat, res);
    total_cnt++;
    if (lat !== 8 || res !== 8'h01) begin
      $display("FAIL shamt_7: lat=%0d result=%h expected 8/01", lat, res);
    end else pass_cnt++;
    release_result();
  endtask

  task automatic test_pass_hold();
    int lat;
    int bad;
    logic [7:0] res;
    issue(8'h5A, 8'd7, 1'b0, 1'b0, lat, res);
    total_cnt++;
    if (lat !== 1 || res !== 8'h5A) begin
      $display("FAIL pass_through: lat=%0d result=%h expected 1/5a", lat, res);
    end else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in1 = 8'h11; in2 = 8'd1; alu_control = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 8'h5A || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (bad !== 0) begin
      $display("FAIL done_hold: %0d unstable cycles expected 0", bad);
    end else pass_cnt++;
    release_result();
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL return_idle: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end else pass_cnt++;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) begin
      $display("FAIL ignored_not_queued: %0d active cycles expected 0", bad);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [7:0] res;
    @(negedge clk);
    in1 = 8'hF3; in2 = 8'd6; alu_control = 1'b1; arith = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL mid_shift_busy: busy=%b out_valid=%b expected 1/0", busy, out_valid);
    end else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (result !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL async_reset: result=%h out_valid=%b busy=%b in_ready=%b expected 00/0/0/1",
               result, out_valid, busy, in_ready);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 0) begin
      $display("FAIL abandoned_op: out_valid seen %0d cycles expected 0", seen);
    end else pass_cnt++;
    issue(8'hB4, 8'd2, 1'b1, 1'b0, lat, res);
    total_cnt++;
    if (lat !== 3 || res !== 8'h2D) begin
      $display("FAIL after_reset_op: lat=%0d result=%h expected 3/2d", lat, res);
    end else pass_cnt++;
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] res;
    issue(8'hF0, 8'd4, 1'b1, 1'b0, lat, res);
    total_cnt++;
    if (lat !== 5 || res !== 8'h0F) begin
      $display("FAIL b2b_first: lat=%0d result=%h expected 5/0f", lat, res);
    end else pass_cnt++;
    release_result();
    issue(8'h0F, 8'd1, 1'b1, 1'b1, lat, res);
    total_cnt++;
    if (lat !== 2 || res !== 8'h07) begin
      $display("FAIL b2b_second: lat=%0d result=%h expected 2/07", lat, res);
    end else pass_cnt++;
    release_result();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0;
    alu_control = 1'b0; arith = 1'b0; out_ready = 1'b0;
    test_reset();
    test_logical();
    test_arith();
    test_saturate();
    test_pass_hold();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
